load_store_unit: RTL and testbench

Load/store unit between the core's memory stage and port B of the dual-port BRAM main memory. It accepts byte, halfword and word requests at any byte address. It generates byte enables and lane-shifted write data, and splits accesses that cross a 32-bit word boundary into two memory beats. On loads it reassembles the data and returns it sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg: shared size encodings, state encoding and address width for the LSU
// Revision: 1.0
// ============================================================================
package lsu_pkg;

  localparam int ADDR_W = 14;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// lsu_lane_align: byte-lane mask, store shift and load extract/extend logic
// Revision: 1.0
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  mask8,
  output logic [63:0] w64,
  output logic [31:0] rdata
);

  logic [3:0]  nmask;
  logic [63:0] r64;

  always_comb begin
    nmask = 4'b0000;
    case (size)
      SZ_BYTE: nmask = 4'b0001;
      SZ_HALF: nmask = 4'b0011;
      SZ_WORD: nmask = 4'b1111;
      default: nmask = 4'b0000;
    endcase

    mask8 = {4'b0000, nmask} << off;
    w64   = {32'b0, wdata} << {off, 3'b000};
    r64   = {hi, lo} >> {off, 3'b000};

    case (size)
      SZ_BYTE: rdata = uns ? {24'b0, r64[7:0]}  : {{24{r64[7]}}, r64[7:0]};
      SZ_HALF: rdata = uns ? {16'b0, r64[15:0]} : {{16{r64[15]}}, r64[15:0]};
      default: rdata = r64[31:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit: byte/half/word access to BRAM port B with split beats
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = lsu_pkg::ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  import lsu_pkg::*;

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;

  logic [7:0]        mask8;
  logic [63:0]       w64;
  logic [31:0]       ext_rdata;
  logic [31:0]       align_lo;
  logic              split;
  logic [ADDR_W-1:0] beat0_addr;
  logic [ADDR_W-1:0] beat1_addr;

  assign split      = |mask8[7:4];
  assign beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_W'(4);
  // An unsplit load returns its only word in CAPT, so lo comes straight from memory.
  assign align_lo   = split ? lo_q : mem_rdata;
  assign req_ready  = (state == IDLE);

  lsu_lane_align u_align (
    .off   (addr_q[1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .wdata (wdata_q),
    .lo    (align_lo),
    .hi    (mem_rdata),
    .mask8 (mask8),
    .w64   (w64),
    .rdata (ext_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      write_q    <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= 32'b0;
      lo_q       <= 32'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[31:0];
            if (req_size == SZ_ILLEGAL) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (split) begin
            state <= BEAT1;
          end else if (write_q) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            state <= CAPT;
          end
        end
        BEAT1: begin
          // Registered BRAM: beat0's word is on mem_rdata while beat1 is addressed.
          lo_q <= mem_rdata[31:0];
          if (write_q) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            state <= CAPT;
          end
        end
        CAPT: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_rdata <= ext_rdata;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    mem_we    = 1'b0;
    case (state)
      BEAT0: begin
        mem_addr = beat0_addr;
        if (write_q) begin
          mem_we    = 1'b1;
          mem_be    = mask8[3:0];
          mem_wdata = w64[31:0];
        end
      end
      BEAT1: begin
        mem_addr = beat1_addr;
        if (write_q) begin
          mem_we    = 1'b1;
          mem_be    = mask8[7:4];
          mem_wdata = w64[63:32];
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit: directed vector bench with a byte-addressed BRAM model
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        clr;

  logic [7:0]  mem [0:16383];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Registered-read BRAM: data appears the cycle after the address.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
      mem_rdata <= 32'h0;
    end else begin
      mem_rdata <= {mem[{mem_addr[13:2], 2'b11}], mem[{mem_addr[13:2], 2'b10}],
                    mem[{mem_addr[13:2], 2'b01}], mem[{mem_addr[13:2], 2'b00}]};
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[{mem_addr[13:2], 2'(b)}] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_wbeats;
    logic [13:0] a0;
    logic [3:0]  be0;
    logic [13:0] a1;
    logic [3:0]  be1;
  } vec_t;

  vec_t vecs [14];

  task automatic run(input vec_t v, input int idx);
    int          lat;
    int          nw;
    int          stray;
    logic [31:0] got_rdata;
    logic        got_fault;
    logic [13:0] wa [2];
    logic [3:0]  wb [2];
    lat = -1; nw = 0; stray = 0; got_rdata = 32'hDEAD_BEEF; got_fault = 1'b0;
    wa[0] = '0; wa[1] = '0; wb[0] = '0; wb[1] = '0;
    @(negedge clk);
    check($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (nw < 2) begin wa[nw] = mem_addr; wb[nw] = mem_be; end
        nw++;
      end else if (mem_be != 4'b0000) begin
        stray++;
      end
      if (resp_valid) begin
        lat = c; got_rdata = resp_rdata; got_fault = resp_fault;
      end
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d rdata", idx), got_rdata, v.exp_rdata);
    check($sformatf("v%0d fault", idx), {31'b0, got_fault}, {31'b0, v.exp_fault});
    check($sformatf("v%0d write_beats", idx), nw, v.exp_wbeats);
    check($sformatf("v%0d be_without_we", idx), stray, 0);
    if (v.exp_wbeats >= 1) begin
      check($sformatf("v%0d beat0_addr", idx), {18'b0, wa[0]}, {18'b0, v.a0});
      check($sformatf("v%0d beat0_be", idx), {28'b0, wb[0]}, {28'b0, v.be0});
    end
    if (v.exp_wbeats >= 2) begin
      check($sformatf("v%0d beat1_addr", idx), {18'b0, wa[1]}, {18'b0, v.a1});
      check($sformatf("v%0d beat1_be", idx), {28'b0, wb[1]}, {28'b0, v.be1});
    end
    @(negedge clk);
    check($sformatf("v%0d pulse_width", idx), {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " resp_fault"}, {31'b0, resp_fault}, 32'd0);
    check({tag, " resp_rdata"}, resp_rdata, 32'd0);
    check({tag, " mem_addr"}, {18'b0, mem_addr}, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, " mem_we"}, {31'b0, mem_we}, 32'd0);
  endtask

  initial begin
    int saw_resp;
    //            wr    sz       uns   addr      wdata         exp_rdata     flt  lat wb a0       be0      a1       be1
    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 14'h0010, 32'h11223344, 32'h00000000, 1'b0, 2, 1, 14'h0010, 4'b1111, 14'h0000, 4'b0000};
    vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 14'h0010, 32'h00000000, 32'h11223344, 1'b0, 3, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 14'h0007, 32'h12345680, 32'h00000000, 1'b0, 2, 1, 14'h0004, 4'b1000, 14'h0000, 4'b0000};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 14'h0007, 32'h00000000, 32'hFFFFFF80, 1'b0, 3, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 14'h0007, 32'h00000000, 32'h00000080, 1'b0, 3, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[5]  = '{1'b1, SZ_WORD, 1'b0, 14'h0006, 32'hAABBCCDD, 32'h00000000, 1'b0, 3, 2, 14'h0004, 4'b1100, 14'h0008, 4'b0011};
    vecs[6]  = '{1'b0, SZ_WORD, 1'b0, 14'h0006, 32'h00000000, 32'hAABBCCDD, 1'b0, 4, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[7]  = '{1'b1, SZ_HALF, 1'b0, 14'h3FFF, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 2, 14'h3FFC, 4'b1000, 14'h0000, 4'b0001};
    vecs[8]  = '{1'b0, SZ_HALF, 1'b0, 14'h3FFF, 32'h00000000, 32'hFFFFBEEF, 1'b0, 4, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[9]  = '{1'b1, SZ_ILLEGAL, 1'b0, 14'h0020, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[10] = '{1'b0, SZ_HALF, 1'b1, 14'h3FFF, 32'h00000000, 32'h0000BEEF, 1'b0, 4, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 14'h0008, 32'h00000000, 32'h000000BB, 1'b0, 3, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[12] = '{1'b0, SZ_HALF, 1'b1, 14'h0005, 32'h00000000, 32'h0000DD00, 1'b0, 3, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};
    vecs[13] = '{1'b0, SZ_HALF, 1'b0, 14'h0007, 32'h00000000, 32'hFFFFBBCC, 1'b0, 4, 0, 14'h0000, 4'b0000, 14'h0000, 4'b0000};

    rst = 1'b1; clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run(vecs[i], i);

    check("byte6", {24'b0, mem[6]}, 32'hDD);
    check("byte7", {24'b0, mem[7]}, 32'hCC);
    check("byte8", {24'b0, mem[8]}, 32'hBB);
    check("byte9", {24'b0, mem[9]}, 32'hAA);
    check("byte3fff", {24'b0, mem[16383]}, 32'hEF);
    check("byte0000", {24'b0, mem[0]}, 32'hBE);

    // Reset in the middle of a split store: beat0 lands, beat1 never issues.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 14'h0106; req_wdata = 32'h55667788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("abort in_beat1 we", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 check_idle_outputs("abort");
    saw_resp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_we) saw_resp++;
    end
    check("abort quiet", saw_resp, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort ready", {31'b0, req_ready}, 32'd1);
    check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort byte106", {24'b0, mem[14'h106]}, 32'h88);
    check("abort byte107", {24'b0, mem[14'h107]}, 32'h77);
    check("abort byte108", {24'b0, mem[14'h108]}, 32'h00);
    check("abort byte109", {24'b0, mem[14'h109]}, 32'h00);
    check("abort byte105", {24'b0, mem[14'h105]}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
